ram_rburst_reader: RTL

- Read-side master for the team's single-clock synchronous RAM. It is the counterpart of the write path.
- Accepts a burst read request (start address and length) over a valid/ready handshake.
- Issues one RAM read per beat with address wrap-around.
- Returns the data as a valid/ready stream with a last-beat marker. A small credit-controlled FIFO absorbs consumer backpressure without losing RAM data.

---
 rtl/ram_rd_pkg.sv | 19 +
 rtl/ram_rburst_reader_if.sv | 31 +++
 rtl/ram_rd_fifo.sv | 55 +++++
 rtl/ram_rburst_reader.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ram_rd_pkg.sv
// Shared types and defaults for the RAM burst read path.
// The FIFO entry struct is the default storage type of the output buffer.
package ram_rd_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
    } rd_entry_t;

endpackage

// File: rtl/ram_rburst_reader_if.sv
// Request, RAM read port and output stream of the burst reader.
// The master modport is the reader's view; slave is the RAM/consumer side.
interface ram_rburst_reader_if #(
    parameter int ADDR_W = ram_rd_pkg::ADDR_W_DEF,
    parameter int DATA_W = ram_rd_pkg::DATA_W_DEF
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_len;
    logic              rd_enb;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic              dout_last;
    logic              busy;

    modport master (
        input  req_valid, req_addr, req_len, rd_data, dout_ready,
        output req_ready, rd_enb, rd_addr, dout_valid, dout_data, dout_last, busy
    );

    modport slave (
        output req_valid, req_addr, req_len, rd_data, dout_ready,
        input  req_ready, rd_enb, rd_addr, dout_valid, dout_data, dout_last, busy
    );

endinterface

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO buffering RAM read data against consumer stalls.
// The writer guarantees it never pushes into a full FIFO.
module ram_rd_fifo
    import ram_rd_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = rd_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_pop;

    assign do_pop = pop && !empty;
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ram_rburst_reader.sv
// Burst read master: issues one RAM read per beat with address wrap and streams the
// returned data through a credit-controlled FIFO so backpressure never drops a beat.
module ram_rburst_reader
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    ram_rburst_reader_if.master  bus
);

    localparam int              CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]  ONE_BEAT = (ADDR_W + 1)'(1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              rd_enb;
    logic              req_ready;
    logic              issue_last;
    logic              credit_ok;
    logic              pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_after_pop;
    beat_t             push_beat;
    beat_t             head_beat;

    // A read may issue only if the beat it returns is guaranteed a FIFO slot.
    assign pop             = !fifo_empty && bus.dout_ready;
    assign count_after_pop = fifo_count - CNT_W'(pop);
    assign credit_ok       = (count_after_pop + CNT_W'(inflight_q)) < DEPTH_C;
    assign issue_last      = (remaining_q == ONE_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = RUN;
            RUN:     if (rd_enb && issue_last) state_d = DRAIN;
            DRAIN:   if (pop && head_beat.last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_enb    = 1'b0;
        req_ready = 1'b0;
        unique case (state_q)
            IDLE:    req_ready = 1'b1;
            RUN:     rd_enb    = credit_ok;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= rd_enb;
            inflight_last_q <= rd_enb && issue_last;
            if (state_q == IDLE && bus.req_valid) begin
                addr_q      <= bus.req_addr;
                remaining_q <= {1'b0, bus.req_len} + ONE_BEAT;
            end else if (rd_enb) begin
                addr_q      <= addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - ONE_BEAT;
            end
        end
    end

    // Read data returns one cycle after rd_enb; reset clears inflight_q so late data is dropped.
    assign push_beat = '{data: bus.rd_data, last: inflight_last_q};

    ram_rd_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (beat_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (push_beat),
        .pop       (pop),
        .head      (head_beat),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign bus.req_ready  = req_ready;
    assign bus.busy       = (state_q != IDLE);
    assign bus.rd_enb     = rd_enb;
    assign bus.rd_addr    = addr_q;
    assign bus.dout_valid = !fifo_empty;
    assign bus.dout_data  = fifo_empty ? '0 : head_beat.data;
    assign bus.dout_last  = !fifo_empty && head_beat.last;

endmodule
